// File: rtl/sw_debounce.sv
// sw_debounce: per-bit two-flop synchronizer and debouncer with registered rise/fall pulses
// and a sticky change mask.
module sw_debounce #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic             clk_clk,
   input  logic             reset_reset_n,
   input  logic [WIDTH-1:0] sw_raw,
   input  logic             chg_clear,
   output logic [WIDTH-1:0] sw_clean,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic [WIDTH-1:0] sw_changed
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   logic [WIDTH-1:0] s1, s2, acc;
   logic [CNT_W-1:0] cnt [WIDTH];
   always_comb begin
      acc = '0;
      for (int i = 0; i < WIDTH; i++)
         acc[i] = (s2[i] != sw_clean[i]) && (cnt[i] == LAST);
   end
   // An accepted bit flips sw_clean; set in sw_changed wins over chg_clear.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         s1         <= '0;
         s2         <= '0;
         sw_clean   <= '0;
         sw_rise    <= '0;
         sw_fall    <= '0;
         sw_changed <= '0;
         for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
         s1         <= sw_raw;
         s2         <= s1;
         sw_clean   <= sw_clean ^ acc;
         sw_rise    <= acc & s2;
         sw_fall    <= acc & ~s2;
         sw_changed <= (chg_clear ? '0 : sw_changed) | acc;
         for (int i = 0; i < WIDTH; i++)
            cnt[i] <= (s2[i] == sw_clean[i] || acc[i]) ? '0 : cnt[i] + 1'b1;
      end
   end
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed checks of sw_debounce with DEBOUNCE_CYCLES=8, WIDTH=4.
module tb_sw_debounce;
   logic       clk_clk = 0;
   logic       reset_reset_n = 0;
   logic [3:0] sw_raw = '0;
   logic       chg_clear = 0;
   logic [3:0] sw_clean, sw_rise, sw_fall, sw_changed;
   int checks = 0, errors = 0;

   sw_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(8)) dut (
      .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .sw_raw(sw_raw),
      .chg_clear(chg_clear), .sw_clean(sw_clean), .sw_rise(sw_rise),
      .sw_fall(sw_fall), .sw_changed(sw_changed));

   always #5 clk_clk = ~clk_clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk_clk);
   endtask

   // n edges with sw_clean held at c and no pulses
   task automatic hold(input int n, input logic [3:0] c, input string tag);
      repeat (n) begin
         step();
         chk({tag, " clean"}, sw_clean, c);
         chk({tag, " rise"}, sw_rise, 4'b0);
         chk({tag, " fall"}, sw_fall, 4'b0);
      end
   endtask

   task automatic expect4(input string tag, input logic [3:0] c, r, f, ch);
      chk({tag, " clean"}, sw_clean, c);
      chk({tag, " rise"}, sw_rise, r);
      chk({tag, " fall"}, sw_fall, f);
      chk({tag, " changed"}, sw_changed, ch);
   endtask

   initial begin
      repeat (3) step();
      expect4("reset", 4'b0, 4'b0, 4'b0, 4'b0);
      reset_reset_n = 1;
      // idle
      repeat (50) begin
         step();
         expect4("idle", 4'b0, 4'b0, 4'b0, 4'b0);
      end
      // basic rise and fall on bit 0
      sw_raw = 4'b0001;
      hold(9, 4'b0000, "t2 pre-rise");
      step();
      expect4("t2 rise", 4'b0001, 4'b0001, 4'b0, 4'b0001);
      step();
      expect4("t2 rise end", 4'b0001, 4'b0, 4'b0, 4'b0001);
      sw_raw = 4'b0000;
      hold(9, 4'b0001, "t2 pre-fall");
      step();
      expect4("t2 fall", 4'b0000, 4'b0, 4'b0001, 4'b0001);
      step();
      expect4("t2 fall end", 4'b0000, 4'b0, 4'b0, 4'b0001);
      chg_clear = 1;
      step();
      chg_clear = 0;
      chk("t2 clear", sw_changed, 4'b0);
      // 7-cycle glitch rejected
      sw_raw = 4'b0010;
      hold(7, 4'b0000, "t3 glitch high");
      sw_raw = 4'b0000;
      hold(15, 4'b0000, "t3 glitch after");
      chk("t3 glitch changed", sw_changed, 4'b0);
      // 8-cycle pulse accepted, then falls back
      sw_raw = 4'b0010;
      hold(8, 4'b0000, "t3 pulse high");
      sw_raw = 4'b0000;
      hold(1, 4'b0000, "t3 pulse low");
      step();
      expect4("t3 accept", 4'b0010, 4'b0010, 4'b0, 4'b0010);
      hold(7, 4'b0010, "t3 pre-fall");
      step();
      expect4("t3 fall", 4'b0000, 4'b0, 4'b0010, 4'b0010);
      // bounce on bit 2 then hold high
      for (int s = 0; s < 6; s++) begin
         sw_raw = (s % 2 == 0) ? 4'b0100 : 4'b0000;
         hold(3, 4'b0000, "t4 bounce");
      end
      sw_raw = 4'b0100;
      hold(9, 4'b0000, "t4 settle");
      step();
      expect4("t4 rise", 4'b0100, 4'b0100, 4'b0, 4'b0110);
      hold(3, 4'b0100, "t4 after");
      // clear racing with bit 3 acceptance
      sw_raw = 4'b1100;
      hold(9, 4'b0100, "t5 pre");
      chg_clear = 1;
      step();
      chg_clear = 0;
      expect4("t5 race", 4'b1100, 4'b1000, 4'b0, 4'b1000);
      step();
      expect4("t5 after", 4'b1100, 4'b0, 4'b0, 4'b1000);
      // async reset with bit 0 counter at 5
      sw_raw = 4'b1101;
      hold(7, 4'b1100, "t6 count");
      #2 reset_reset_n = 0;
      #1 expect4("t6 async", 4'b0, 4'b0, 4'b0, 4'b0);
      step();
      expect4("t6 held", 4'b0, 4'b0, 4'b0, 4'b0);
      reset_reset_n = 1;
      hold(9, 4'b0000, "t6 post");
      step();
      expect4("t6 rise", 4'b1101, 4'b1101, 4'b0, 4'b1101);
      step();
      expect4("t6 rise end", 4'b1101, 4'b0, 4'b0, 4'b1101);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
